// File: rtl/tick_scheduler.sv
// tick_scheduler: shares one second-tick timer among NUM_CH independent countdown channels.
// Define TICK_SCHED_FIXED_PRIO_EN for fixed-priority arbitration; default is round-robin.

module tick_sched_ch #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             tick,
  input  logic             accept,
  input  logic             cancel,
  input  logic [CNT_W-1:0] seconds,
  output logic             busy,
  output logic             busy_d,
  output logic             expired
);
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             exp_d;

  always_comb begin
    busy_d = busy;
    cnt_d  = cnt;
    exp_d  = 1'b0;
    if (busy) begin
      // cancel beats a coincident final tick
      if (cancel) begin
        busy_d = 1'b0;
      end else if (tick && cnt != '0) begin
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy_d = 1'b0;
          exp_d  = 1'b1;
        end
      end
    end else if (accept) begin
      if (seconds == '0) begin
        exp_d = 1'b1;
      end else begin
        cnt_d  = seconds;
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      busy    <= 1'b0;
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      busy    <= busy_d;
      cnt     <= cnt_d;
      expired <= exp_d;
    end
  end
endmodule

module tick_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    second_tick,
  output logic                    timer_enable,
  output logic                    timer_rst,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*CNT_W-1:0] req_seconds,
  output logic [NUM_CH-1:0]       req_ready,
  input  logic [NUM_CH-1:0]       cancel,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expired
);
  logic [NUM_CH-1:0] eligible, accept, arm, busy_d;

  assign eligible = req_valid & ~busy & ~cancel;
  assign accept   = req_valid & req_ready;

`ifdef TICK_SCHED_FIXED_PRIO_EN
  always_comb begin
    req_ready = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        req_ready    = '0;
        req_ready[i] = 1'b1;
      end
    end
  end
`else
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr, ptr_d;
  int               idx;
  logic             found;

  // search starts at ptr and wraps; the pointer parks just past the winner
  always_comb begin
    req_ready = '0;
    ptr_d     = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found          = 1'b1;
        req_ready[idx] = 1'b1;
        ptr_d          = (idx == NUM_CH - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) ptr <= '0;
    else       ptr <= ptr_d;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] secs;
    assign secs   = req_seconds[i*CNT_W +: CNT_W];
    assign arm[i] = accept[i] && (secs != '0);

    tick_sched_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst_i   (rst_i),
      .tick    (second_tick),
      .accept  (accept[i]),
      .cancel  (cancel[i]),
      .seconds (secs),
      .busy    (busy[i]),
      .busy_d  (busy_d[i]),
      .expired (expired[i])
    );
  end

  // the timer is only re-phased when the first channel arms from an all-idle state
  always_ff @(posedge clk) begin
    if (rst_i) begin
      timer_enable <= 1'b0;
      timer_rst    <= 1'b0;
    end else begin
      timer_enable <= |busy_d;
      timer_rst    <= (|arm) && !(|busy);
    end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: hand-derived vector table, directed corner sequences,
// and random traffic against a seconds-remaining reference model.
`timescale 1ns/1ps
module tb_tick_scheduler;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_i, second_tick;
  logic                    timer_enable, timer_rst;
  logic [NUM_CH-1:0]       req_valid, req_ready, cancel, busy, expired;
  logic [NUM_CH*CNT_W-1:0] req_seconds;

  tick_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_i(rst_i), .second_tick(second_tick),
    .timer_enable(timer_enable), .timer_rst(timer_rst),
    .req_valid(req_valid), .req_seconds(req_seconds), .req_ready(req_ready),
    .cancel(cancel), .busy(busy), .expired(expired)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model: seconds remaining per channel, 0 means idle
  int                m_rem [NUM_CH];
  logic [NUM_CH-1:0] m_exp;
  logic              m_ten, m_trst;
  int                m_ptr;
  logic [NUM_CH-1:0] rdy_seen, obs_exp;
  logic              obs_trst;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [NUM_CH-1:0] e_rdy, logic [NUM_CH-1:0] e_busy,
                         logic [NUM_CH-1:0] e_exp, logic e_ten, logic e_trst);
    chk({tag, ".req_ready"},    32'(req_ready),    32'(e_rdy));
    chk({tag, ".busy"},         32'(busy),         32'(e_busy));
    chk({tag, ".expired"},      32'(expired),      32'(e_exp));
    chk({tag, ".timer_enable"}, 32'(timer_enable), 32'(e_ten));
    chk({tag, ".timer_rst"},    32'(timer_rst),    32'(e_trst));
  endtask

  function automatic logic [NUM_CH-1:0] m_busy();
    logic [NUM_CH-1:0] b = '0;
    for (int i = 0; i < NUM_CH; i++) b[i] = (m_rem[i] > 0);
    return b;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ready();
    logic [NUM_CH-1:0] r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef TICK_SCHED_FIXED_PRIO_EN
      int i = k;
`else
      int i = (m_ptr + k) % NUM_CH;
`endif
      if (r == '0 && req_valid[i] && m_rem[i] == 0 && !cancel[i]) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_update(logic [NUM_CH-1:0] g);
    logic was_busy = (m_busy() != '0);
    m_trst = 1'b0;
    m_exp  = '0;
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
      m_ten = 1'b0;
      m_ptr = 0;
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      int s = int'(req_seconds[i*CNT_W +: CNT_W]);
      if (m_rem[i] > 0) begin
        if (cancel[i]) m_rem[i] = 0;
        else if (second_tick) begin
          m_rem[i] = m_rem[i] - 1;
          m_exp[i] = (m_rem[i] == 0);
        end
      end else if (g[i]) begin
        if (s == 0) m_exp[i] = 1'b1;
        else begin
          m_rem[i] = s;
          if (!was_busy) m_trst = 1'b1;
        end
        m_ptr = (i + 1) % NUM_CH;
      end
    end
    m_ten = (m_busy() != '0);
  endfunction

  // one clock: compare at the falling edge, advance the model at the rising edge
  task automatic step(string tag);
    logic [NUM_CH-1:0] r;
    @(negedge clk);
    r        = model_ready();
    rdy_seen = req_ready;
    obs_exp  = expired;
    obs_trst = timer_rst;
    chk_all(tag, r, m_busy(), m_exp, m_ten, m_trst);
    @(posedge clk);
    model_update(r);
    #1;
  endtask

  typedef struct {
    logic              rst, tick;
    logic [NUM_CH-1:0] valid, cncl;
    logic [31:0]       secs;
    logic [NUM_CH-1:0] e_rdy, e_busy, e_exp;
    logic              e_ten, e_trst;
  } vec_t;

  function automatic vec_t v(logic rst, logic tick, logic [3:0] valid, logic [3:0] cncl,
                             logic [31:0] secs, logic [3:0] e_rdy, logic [3:0] e_busy,
                             logic [3:0] e_exp, logic e_ten, logic e_trst);
    vec_t r;
    r.rst = rst; r.tick = tick; r.valid = valid; r.cncl = cncl; r.secs = secs;
    r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_exp = e_exp; r.e_ten = e_ten; r.e_trst = e_trst;
    return r;
  endfunction

  vec_t vecs [15];
  int   order [$];
  int   exp1 [4] = '{0, 1, 2, 3};
`ifdef TICK_SCHED_FIXED_PRIO_EN
  int   exp2 [4] = '{0, 1, 2, 3};
`else
  int   exp2 [4] = '{2, 3, 0, 1};
`endif

  task automatic contend(string tag, int expo [4]);
    order.delete();
    req_valid   = '1;
    req_seconds = 32'h04030201;
    for (int c = 0; c < 8 && req_valid != '0; c++) begin
      step(tag);
      for (int j = 0; j < NUM_CH; j++)
        if (rdy_seen[j]) begin
          order.push_back(j);
          req_valid[j] = 1'b0;
        end
    end
    req_valid = '0;
    chk({tag, ".grant_count"}, 32'(order.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      chk({tag, ".grant_order"}, (j < order.size()) ? 32'(order[j]) : 32'hffff_ffff, 32'(expo[j]));
    cancel = '1; step({tag, "_cancel"});
    cancel = '0; step({tag, "_idle"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n_trst, n_exp0;
    for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
    m_exp = '0; m_ten = 1'b0; m_trst = 1'b0; m_ptr = 0;
    rst_i = 1'b1; second_tick = 1'b0; req_valid = '0; req_seconds = '0; cancel = '0;
    repeat (2) @(posedge clk);
    #1;

    vecs[0]  = v(1'b1, 1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[1]  = v(1'b0, 1'b0, 4'b0100, 4'b0000, 32'h0,        4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[2]  = v(1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0);
    vecs[3]  = v(1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[4]  = v(1'b0, 1'b0, 4'b0001, 4'b0000, 32'h2,        4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[5]  = v(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b1);
    vecs[6]  = v(1'b0, 1'b0, 4'b1000, 4'b0000, 32'h01000000, 4'b1000, 4'b0001, 4'b0000, 1'b1, 1'b0);
    vecs[7]  = v(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b1001, 4'b0000, 1'b1, 1'b0);
    vecs[8]  = v(1'b0, 1'b0, 4'b0001, 4'b0000, 32'h1,        4'b0001, 4'b0000, 4'b1001, 1'b0, 1'b0);
    vecs[9]  = v(1'b0, 1'b0, 4'b0000, 4'b0001, 32'h0,        4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b1);
    vecs[10] = v(1'b0, 1'b0, 4'b0010, 4'b0000, 32'h100,      4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[11] = v(1'b0, 1'b1, 4'b0000, 4'b0010, 32'h0,        4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1);
    vecs[12] = v(1'b0, 1'b0, 4'b0001, 4'b0001, 32'h3,        4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[13] = v(1'b0, 1'b1, 4'b0000, 4'b1111, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    vecs[14] = v(1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    for (int r = 0; r < 15; r++) begin
      logic [NUM_CH-1:0] g;
      rst_i = vecs[r].rst; second_tick = vecs[r].tick; req_valid = vecs[r].valid;
      cancel = vecs[r].cncl; req_seconds = vecs[r].secs;
      @(negedge clk);
      g = model_ready();
      chk_all($sformatf("vec%0d", r), vecs[r].e_rdy, vecs[r].e_busy, vecs[r].e_exp,
              vecs[r].e_ten, vecs[r].e_trst);
      @(posedge clk);
      model_update(g);
      #1;
    end
    rst_i = 1'b0; second_tick = 1'b0; req_valid = '0; cancel = '0; req_seconds = '0;

    // ch0 for 3 s with a tick every 20 cycles
    req_valid = 4'b0001; req_seconds = 32'd3;
    step("s1_arm");
    req_valid = '0;
    n_trst = 0; n_exp0 = 0;
    for (int c = 0; c < 80; c++) begin
      second_tick = (c % 20 == 19);
      step("s1");
      n_trst += int'(obs_trst);
      n_exp0 += int'(obs_exp[0]);
    end
    second_tick = 1'b0;
    chk("s1.timer_rst_pulses", 32'(n_trst), 32'd1);
    chk("s1.expired0_pulses", 32'(n_exp0), 32'd1);
    chk("s1.busy_after", 32'(busy), 32'd0);
    chk("s1.enable_after", 32'(timer_enable), 32'd0);

    // contention rounds: from pointer 0, then from pointer 2
    rst_i = 1'b1; step("s2_rst"); rst_i = 1'b0;
    contend("s2_r1", exp1);
    req_valid = 4'b0010; step("s2_ptr"); req_valid = '0;
    cancel = 4'b0010; step("s2_ptr_cancel"); cancel = '0;
    contend("s2_r2", exp2);

    // reset in the middle of a countdown
    req_valid = 4'b0011; req_seconds = 32'h0505;
    step("s3_arm_a"); step("s3_arm_b");
    req_valid = '0;
    second_tick = 1'b1; step("s3_tick"); second_tick = 1'b0;
    rst_i = 1'b1; step("s3_rst0"); step("s3_rst1"); rst_i = 1'b0;
    chk("s3.busy_after_rst", 32'(busy), 32'd0);
    chk("s3.enable_after_rst", 32'(timer_enable), 32'd0);
    for (int c = 0; c < 12; c++) begin
      second_tick = c[0];
      step("s3_post");
    end
    second_tick = 1'b0;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rst_i       = ($urandom_range(0, 199) == 0);
      second_tick = ($urandom_range(0, 3) == 0);
      req_valid   = NUM_CH'($urandom) & NUM_CH'($urandom);
      cancel      = ($urandom_range(0, 11) == 0) ? NUM_CH'($urandom) : '0;
      for (int i = 0; i < NUM_CH; i++) req_seconds[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shares the single one-second `timer` instance among up to `NUM_CH` requesters, each of which arms an independent countdown measured in seconds. The block accepts arm requests through a ready/valid handshake, with at most one grant per cycle. It drives the timer's `enable` and `rst_i` inputs and consumes its `second_tick` pulse. It is used for per-engine timeouts and rate limiting in the accelerator control path.

## Interface
- `NUM_CH`, 4, number of requester channels (1–16)
- `CNT_W`, 8, width of each requested duration in seconds
- `clk` in 1: system clock, all logic on rising edge
- `rst_i` in 1: synchronous, active-high reset
- `second_tick` in 1: one-cycle pulse from `timer`
- `timer_enable` out 1: drives `timer.enable`
- `timer_rst` out 1: drives `timer.rst_i`
- `req_valid` in `NUM_CH`: per-channel arm request
- `req_seconds` in `NUM_CH*CNT_W`: duration for channel i in bits [i*CNT_W +: CNT_W]
- `req_ready` out `NUM_CH`: combinational grant, at most one bit set
- `cancel` in `NUM_CH`: per-channel abort
- `busy` out `NUM_CH`: channel armed (registered)
- `expired` out `NUM_CH`: one-cycle pulse when a countdown completes (registered)

## Operation
- Per-channel state is IDLE or ARMED. `busy[i]` is 1 exactly in ARMED. Each channel has a `CNT_W` counter `cnt[i]`.
- Eligible channel: `req_valid[i] & ~busy[i] & ~cancel[i]`. The arbiter sets `req_ready` on one eligible channel. A transfer occurs when `req_valid[i] & req_ready[i]`.
- On accept with `req_seconds` = 0: the channel stays IDLE and `expired[i]` pulses the next cycle.
- On accept with `req_seconds` = S > 0: `cnt[i]` <= S and the channel goes ARMED.
- While ARMED, each `second_tick` decrements `cnt[i]`. On the tick where `cnt[i]` == 1, the channel returns to IDLE and `expired[i]` pulses.
- Cancel behaviour:
  - `cancel[i]` while ARMED returns the channel to IDLE with no `expired` pulse.
  - Cancel wins over a simultaneous final tick.
  - Cancel on an IDLE channel has no effect.
- Re-arm requires IDLE. `req_ready[i]` is 0 while `busy[i]`, including the cycle in which `expired[i]` is asserted is not blocked: the channel is already IDLE then and may be re-armed.
- Timer control:
  - `timer_enable` = OR of `busy`, registered form.
  - When a channel arms with no channel busy, `timer_rst` pulses for one cycle so the first second starts at a known phase.
  - When a channel arms while others are busy, the timer is not reset. The first decrement may then arrive 1 to TICKS cycles later; countdown resolution is ±1 second.
- Counters never wrap: decrement occurs only in ARMED with `cnt` ≥ 1.

## Timing
- Reset values: all outputs 0, all channels IDLE, counters 0, round-robin pointer 0. `rst_i` mid-countdown drops every channel to IDLE with no `expired` pulse. `timer_rst` is also held 0 during reset; the timer is reset by the system `rst_i`.
- Accept at edge N: `busy[i]` is 1 from N+1. `timer_rst` is 1 during cycle N+1 only if `busy` was all-zero before N. `timer_enable` is 1 from N+1.
- Final `second_tick` sampled at edge M: `busy[i]` is 0 and `expired[i]` is 1 during cycle M+1 only. `timer_enable` falls at M+1 if no other channel is busy.
- Zero-duration accept at edge N: `expired[i]` is 1 during cycle N+1 and `busy` is never set.
- Multiple channels expiring on the same tick all pulse `expired` in the same cycle.
- `req_ready` depends combinationally on `req_valid`, `busy`, `cancel` and the pointer. It does not depend on `second_tick`.

## Configuration
- `TICK_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest eligible index wins, no pointer state.
  - Undefined (default): round-robin. After a grant to channel g the pointer moves to g+1 mod `NUM_CH`, and the search starts at the pointer.

## Test plan
- Reset, arm ch0 with 3 s, drive `second_tick` every 20 cycles -> `timer_rst` pulses once; `expired[0]` fires one cycle after the 3rd tick; `busy[0]` is 0 and `timer_enable` is 0 afterwards.
- ch0–ch3 request simultaneously (1, 2, 3, 4 s) in round-robin mode -> grants in order 0, 1, 2, 3 on consecutive cycles; a second contention round starting at pointer 2 grants 2, 3, 0, 1. With the macro defined, grants are always 0 first.
- Arm ch1 with 5 s, assert `cancel[1]` on the same cycle as the 5th tick -> no `expired[1]`, `busy[1]` is 0, and `timer_enable` drops.
- Arm ch2 with 0 s -> `expired[2]` pulses at N+1, `busy[2]` never rises, and `timer_enable` stays 0.
- Arm ch0 with 2 s; after 1 tick arm ch3 with 1 s -> no second `timer_rst` pulse; both `expired[0]` and `expired[3]` pulse on the cycle after the next tick.
- Arm ch0 and ch1, assert `rst_i` mid-countdown -> all `busy`, `expired`, `timer_enable` and `req_ready` outputs are 0; subsequent ticks produce no pulses.
